// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-detection inputs and pipeline-register controls of the stall/flush controller.
// slave: the controller; master: the pipeline datapath that feeds it and obeys it.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 16
);
  logic [REG_ADDR_W-1:0]  id_rs1;
  logic [REG_ADDR_W-1:0]  id_rs2;
  logic                   id_uses_rs1;
  logic                   id_uses_rs2;
  logic                   ex_mem_read;
  logic [REG_ADDR_W-1:0]  ex_rd;
  logic                   ex_branch_taken;
  logic                   mem_req;
  logic                   mem_ready;
  logic                   pc_write;
  logic                   if_id_write;
  logic                   if_id_flush;
  logic                   id_ex_write;
  logic                   id_ex_flush;
  logic                   ex_mem_write;
  logic [STALL_CNT_W-1:0] stall_count;

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_rd,
           ex_branch_taken, mem_req, mem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
           ex_mem_write, stall_count
  );

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_rd,
           ex_branch_taken, mem_req, mem_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
           ex_mem_write, stall_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage RV32 pipeline: load-use bubble, branch flush, memory freeze.
// Optional macro HAZARD_STALL_COUNT_EN builds the saturating stall-cycle counter; otherwise stall_count is 0.
//
// state    | meaning
// RUN      | normal flow, all hazards evaluated
// BUBBLE   | one-cycle bubble after load-use; load has left EX so load-use is not re-checked
// MEM_WAIT | data memory busy; whole pipeline frozen until mem_ready
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 16
) (
  input logic                  clock,
  input logic                  reset,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {RUN, BUBBLE, MEM_WAIT} state_t;

  state_t state_q, state_d;
  logic   load_use;
  logic   frozen;
  logic   pc_write_c, if_id_write_c, if_id_flush_c;
  logic   id_ex_write_c, id_ex_flush_c, ex_mem_write_c;

  assign load_use = hz.ex_mem_read && (hz.ex_rd != '0) &&
                    ((hz.id_uses_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                     (hz.id_uses_rs2 && (hz.id_rs2 == hz.ex_rd)));

  // In MEM_WAIT only mem_ready matters; elsewhere a new unfinished request freezes.
  assign frozen = (state_q == MEM_WAIT) ? !hz.mem_ready : (hz.mem_req && !hz.mem_ready);

  always_ff @(posedge clock) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d        = RUN;
    pc_write_c     = 1'b1;
    if_id_write_c  = 1'b1;
    id_ex_write_c  = 1'b1;
    ex_mem_write_c = 1'b1;
    if_id_flush_c  = 1'b0;
    id_ex_flush_c  = 1'b0;
    if (reset) begin
      pc_write_c     = 1'b0;
      if_id_write_c  = 1'b0;
      id_ex_write_c  = 1'b0;
      ex_mem_write_c = 1'b0;
      if_id_flush_c  = 1'b1;
      id_ex_flush_c  = 1'b1;
    end else if (frozen) begin
      pc_write_c     = 1'b0;
      if_id_write_c  = 1'b0;
      id_ex_write_c  = 1'b0;
      ex_mem_write_c = 1'b0;
      state_d        = MEM_WAIT;
    end else if (hz.ex_branch_taken) begin
      // Squashing ID also discards any load-use hazard it carried.
      if_id_flush_c = 1'b1;
      id_ex_flush_c = 1'b1;
    end else if (load_use && (state_q != BUBBLE)) begin
      pc_write_c    = 1'b0;
      if_id_write_c = 1'b0;
      id_ex_flush_c = 1'b1;
      state_d       = BUBBLE;
    end
  end

  assign hz.pc_write     = pc_write_c;
  assign hz.if_id_write  = if_id_write_c;
  assign hz.if_id_flush  = if_id_flush_c;
  assign hz.id_ex_write  = id_ex_write_c;
  assign hz.id_ex_flush  = id_ex_flush_c;
  assign hz.ex_mem_write = ex_mem_write_c;

`ifdef HAZARD_STALL_COUNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge clock) begin
    if (reset)
      stall_cnt_q <= '0;
    else if (!pc_write_c && (stall_cnt_q != {STALL_CNT_W{1'b1}}))
      stall_cnt_q <= stall_cnt_q + 1'b1;
  end

  assign hz.stall_count = stall_cnt_q;
`else
  assign hz.stall_count = '0;
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage RV32 pipeline. It drives the write-enable and flush controls of the PC and of the IF_ID, ID_EX and EX_MEM pipeline registers. It resolves three cases:
- load-use data hazards, by inserting one bubble;
- taken branches, by flushing the two younger stages;
- data-memory wait states, by freezing the whole pipeline.

Parameters:
REG_ADDR_W, 5, register-index width
STALL_CNT_W, 16, width of stall-cycle counter

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
id_rs1  input  REG_ADDR_W  rs1 index of instruction in ID
id_rs2  input  REG_ADDR_W  rs2 index of instruction in ID
id_uses_rs1  input  1  ID instruction reads rs1
id_uses_rs2  input  1  ID instruction reads rs2
ex_mem_read  input  1  instruction in EX is a load
ex_rd  input  REG_ADDR_W  destination of instruction in EX
ex_branch_taken  input  1  branch/jump in EX resolved taken
mem_req  input  1  MEM stage issuing data-memory access
mem_ready  input  1  data memory completes access this cycle
pc_write  output  1  PC update enable
if_id_write  output  1  IF_ID load enable
if_id_flush  output  1  IF_ID clear to NOP
id_ex_write  output  1  ID_EX load enable
id_ex_flush  output  1  ID_EX clear to bubble
ex_mem_write  output  1  EX_MEM load enable
stall_count  output  STALL_CNT_W  cycles with pc_write=0 since reset

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- FSM states: RUN, BUBBLE, MEM_WAIT. All control outputs are combinational from state plus inputs and act in the same cycle.
- Default (no event): all *_write=1, all *_flush=0.

Reset:
- While reset=1: pc_write=0, if_id_write=0, id_ex_write=0, ex_mem_write=0, if_id_flush=1, id_ex_flush=1.
- Next state is RUN and stall_count is 0.
- Reset overrides every state, including MEM_WAIT mid-wait.

Hazard definition:
- load_use = ex_mem_read && ex_rd!=0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)).

Priority per cycle: memory stall > branch flush > load-use.

RUN state:
- mem_req && !mem_ready: freeze. All *_write=0, flushes=0. Next state MEM_WAIT.
- else ex_branch_taken: if_id_flush=1, id_ex_flush=1, writes=1. Stay RUN. A load-use hazard in the same cycle is discarded because the ID instruction is squashed.
- else load_use: pc_write=0, if_id_write=0, id_ex_flush=1, ex_mem_write=1. Next state BUBBLE.
- else: default.

BUBBLE state:
- Lasts exactly 1 cycle. The load has moved to MEM, so load_use is not evaluated.
- Memory stall and branch rules apply as in RUN (a branch cannot be in EX here, since EX holds the bubble).
- Next state RUN, or MEM_WAIT if frozen.

MEM_WAIT state:
- mem_ready=0: full freeze (all writes 0). ex_branch_taken and load_use are ignored.
- mem_ready=1: release this cycle and evaluate branch/load-use exactly as in RUN, using the held EX/ID contents. Next state RUN or BUBBLE accordingly.

mem_ready:
- mem_ready=1 with mem_req=0 is ignored.
- mem_ready=1 in the same cycle as mem_req causes no stall.

stall_count:
- Increments on each non-reset cycle with pc_write=0.
- Saturates at all-ones and does not wrap.

Optional Feature:
- Macro: HAZARD_STALL_COUNT_EN.
- Defined: stall_count is implemented as described.
- Undefined: no counter register; stall_count is tied to 0. All control outputs are unchanged.

Test Plan:
- Load-use: lw x5 in EX (ex_mem_read=1, ex_rd=5); ID add reads rs1=5 -> one cycle with pc_write=0, if_id_write=0, id_ex_flush=1; following cycle all writes=1; stall_count=1.
- x0 / unused operand: ex_rd=0 matching id_rs1=0, and separately id_rs2=5 with id_uses_rs2=0 -> no stall, outputs stay at default.
- Branch flush: ex_branch_taken=1 while load_use is also true -> if_id_flush=1, id_ex_flush=1, pc_write=1, no BUBBLE entered.
- Memory wait: mem_req=1, mem_ready low for 3 cycles then high -> 3 cycles with all writes=0, release on the ready cycle, stall_count=3.
- Freeze plus branch: ex_branch_taken=1 throughout a 2-cycle wait -> no flush while frozen; flush asserted exactly on the mem_ready cycle.
- Reset mid-wait: reset=1 during MEM_WAIT -> flushes=1, writes=0, stall_count=0. After release, RUN with default outputs. Also check saturation with STALL_CNT_W=4 forced stalls: value holds at 15.
